// File: rtl/controller_event_latch_pkg.sv
// Shared layout of the 32-bit controller word plus small helpers.
// The game-logic decoder imports the same constants to unpack the word.
package ctrl_pkg;

  localparam int CTRL_VALID_BIT   = 31;
  localparam int CTRL_COUNT_LSB   = 24;
  localparam int CTRL_COUNT_W     = 7;
  localparam int CTRL_LEVEL_LSB   = 8;
  localparam int CTRL_MAX_BUTTONS = 8;

  localparam int CTRL_POPCOUNT_W  = $clog2(CTRL_MAX_BUTTONS + 1);

  localparam logic [CTRL_COUNT_W-1:0] CTRL_COUNT_MAX = '1;

  function automatic logic [CTRL_POPCOUNT_W-1:0] popcount(
    input logic [CTRL_MAX_BUTTONS-1:0] vec
  );
    logic [CTRL_POPCOUNT_W-1:0] total;
    total = '0;
    for (int i = 0; i < CTRL_MAX_BUTTONS; i++) begin
      total = total + CTRL_POPCOUNT_W'(vec[i]);
    end
    return total;
  endfunction

  // Adds without wrapping: the count pins at CTRL_COUNT_MAX.
  function automatic logic [CTRL_COUNT_W-1:0] sat_add(
    input logic [CTRL_COUNT_W-1:0]    base,
    input logic [CTRL_POPCOUNT_W-1:0] inc
  );
    logic [CTRL_COUNT_W:0] sum;
    sum = {1'b0, base} + (CTRL_COUNT_W + 1)'(inc);
    return sum[CTRL_COUNT_W] ? CTRL_COUNT_MAX : sum[CTRL_COUNT_W-1:0];
  endfunction

endpackage

// File: rtl/controller_event_latch_if.sv
// Button/ack inputs and controller status word between the board side and the processor.
// master drives buttons and ack; slave is the latch that produces the word.
interface controller_event_latch_if #(
  parameter int NUM_BUTTONS = 8
) ();

  logic [NUM_BUTTONS-1:0] buttons_raw;
  logic                   ack;
  logic [31:0]            controller;

  modport master (
    output buttons_raw,
    output ack,
    input  controller
  );

  modport slave (
    input  buttons_raw,
    input  ack,
    output controller
  );

endinterface

// File: rtl/controller_event_latch_button_debouncer.sv
// One button: two-flop synchroniser, stable-count debouncer, and rising-edge detect
// of the debounced level against its one-cycle-delayed copy.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_edge
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_reg;
  logic             sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             level_reg;
  logic             level_next;
  logic             level_d_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_reg    <= 1'b0;
      sync_reg    <= 1'b0;
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
    end else begin
      meta_reg    <= raw;
      sync_reg    <= meta_reg;
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      level_d_reg <= level_reg;
    end
  end

  // Any cycle where sync agrees with the level restarts the stability count.
  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    if (sync_reg == level_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      level_next = sync_reg;
      cnt_next   = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  assign level      = level_reg;
  assign press_edge = level_reg & ~level_d_reg;

endmodule

// File: rtl/controller_event_latch.sv
// Debounces each controller button and latches presses into a sticky pending word with a
// saturating press count; a rising edge of ack clears the latched presses.
module controller_event_latch
  import ctrl_pkg::*;
#(
  parameter int NUM_BUTTONS     = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic                    clock,
  input  logic                    reset,
  controller_event_latch_if.slave bus
);

  logic [NUM_BUTTONS-1:0]      level;
  logic [NUM_BUTTONS-1:0]      press_edge;
  logic [CTRL_MAX_BUTTONS-1:0] press_edge_ext;
  logic [CTRL_POPCOUNT_W-1:0]  press_cnt;

  logic                        ack_d_reg;
  logic                        ack_rise;
  logic [NUM_BUTTONS-1:0]      pending_reg;
  logic [NUM_BUTTONS-1:0]      pending_next;
  logic [CTRL_COUNT_W-1:0]     count_reg;
  logic [CTRL_COUNT_W-1:0]     count_next;
  logic [31:0]                 word;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_button
      button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_debouncer (
        .clock      (clock),
        .reset      (reset),
        .raw        (bus.buttons_raw[gi]),
        .level      (level[gi]),
        .press_edge (press_edge[gi])
      );
    end
  endgenerate

  always_comb begin
    press_edge_ext                  = '0;
    press_edge_ext[NUM_BUTTONS-1:0] = press_edge;
  end

  assign press_cnt = popcount(press_edge_ext);
  assign ack_rise  = bus.ack & ~ack_d_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_d_reg   <= 1'b0;
      pending_reg <= '0;
      count_reg   <= '0;
    end else begin
      ack_d_reg   <= bus.ack;
      pending_reg <= pending_next;
      count_reg   <= count_next;
    end
  end

  // Presses landing in the same cycle as the acknowledge are kept, not swallowed by it.
  always_comb begin
    pending_next = pending_reg | press_edge;
    count_next   = sat_add(count_reg, press_cnt);
    if (ack_rise) begin
      pending_next = press_edge;
      count_next   = CTRL_COUNT_W'(press_cnt);
    end
  end

  always_comb begin
    word                                   = '0;
    word[NUM_BUTTONS-1:0]                  = pending_reg;
    word[CTRL_LEVEL_LSB +: NUM_BUTTONS]    = level;
    word[CTRL_COUNT_LSB +: CTRL_COUNT_W]   = count_reg;
    word[CTRL_VALID_BIT]                   = |pending_reg;
  end

  assign bus.controller = word;

endmodule
